// File: rtl/traffic_light_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor_pkg
// Purpose  : Shared types and constants for the traffic light monitor:
//            lamp-vector bit order, decoded phase codes, fault codes, the
//            monitor state enumeration and small decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package traffic_light_monitor_pkg;

  // Lamp vector: bit0 red, bit1 yellow, bit2 green
  localparam int LAMP_RED_BIT    = 0;
  localparam int LAMP_YELLOW_BIT = 1;
  localparam int LAMP_GREEN_BIT  = 2;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_NONE   = 3'b000;
  localparam lamp_t LAMP_RED    = 3'b001;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b100;

  // Decoded phase output; Y2R shares code 0 with SYNC and is told apart by sync_n
  localparam logic [1:0] PH_SYNC  = 2'd0;
  localparam logic [1:0] PH_RED   = 2'd1;
  localparam logic [1:0] PH_Y2G   = 2'd2;
  localparam logic [1:0] PH_GREEN = 2'd3;
  localparam logic [1:0] PH_Y2R   = 2'd0;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE       = 3'd0;
  localparam err_code_t ERR_NOT_ONEHOT = 3'd1;
  localparam err_code_t ERR_ILLEGAL    = 3'd2;
  localparam err_code_t ERR_SHORT      = 3'd3;
  localparam err_code_t ERR_LONG       = 3'd4;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_RED   = 3'd1,
    ST_Y2G   = 3'd2,
    ST_GREEN = 3'd3,
    ST_Y2R   = 3'd4
  } state_e;

  function automatic logic is_onehot(input lamp_t l);
    return (l == LAMP_RED) || (l == LAMP_YELLOW) || (l == LAMP_GREEN);
  endfunction

  // Lamp that is expected to be lit while sitting in a given state
  function automatic lamp_t state_lamp(input state_e s);
    lamp_t l;
    case (s)
      ST_RED:   l = LAMP_RED;
      ST_Y2G:   l = LAMP_YELLOW;
      ST_GREEN: l = LAMP_GREEN;
      ST_Y2R:   l = LAMP_YELLOW;
      default:  l = LAMP_NONE;
    endcase
    return l;
  endfunction

  function automatic logic [1:0] state_phase(input state_e s);
    logic [1:0] p;
    case (s)
      ST_RED:   p = PH_RED;
      ST_Y2G:   p = PH_Y2G;
      ST_GREEN: p = PH_GREEN;
      ST_Y2R:   p = PH_Y2R;
      default:  p = PH_SYNC;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module   : tl_dwell_counter
// Purpose  : Loadable saturating up-counter with compare-to-limit outputs.
//            Priority: rst > clr_i (load 0) > load_i (load 1) > inc_i.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            clr_i           - force count to 0
//            load_i          - force count to 1 (first cycle of a phase)
//            inc_i           - increment, saturating at all-ones
//            limit_i         - compare value
//            count_o         - registered count
//            at_limit_o      - count_o == limit_i
//            below_limit_o   - count_o <  limit_i
// Revision : 1.0 - initial release
// ============================================================================
module tl_dwell_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o,
  output logic             below_limit_o
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= C_ONE;
    end else if (inc_i && (count_q != C_MAX)) begin
      count_q <= count_q + C_ONE;
    end
  end

  assign count_o       = count_q;
  assign at_limit_o    = (count_q == limit_i);
  assign below_limit_o = (count_q <  limit_i);

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Watches the three lamps of a traffic light, tracks the
//            RED -> Y2G -> GREEN -> Y2R cycle, checks one-hot lamps, legal
//            transitions and per-phase dwell times, and reports faults and
//            completed cycles. All outputs are registered.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            red, yellow, green  - observed lamps
//            phase               - 0 SYNC/Y2R, 1 RED, 2 Y2G, 3 GREEN
//            dwell               - cycles current lamp held (1 on entry)
//            sync_n              - 1 while tracking the cycle
//            error               - sticky fault flag
//            err_code            - code of first fault since reset
//            err_count           - saturating fault count
//            cycle_done          - pulse per fault-free Y2R->RED
//            cycle_count         - wrapping count of cycle_done pulses
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  // Each timer must lie in 1..14 so the dwell counter never saturates first
  parameter int GREENTIMER  = 6,
  parameter int YELLOWTIMER = 2,
  parameter int REDTIMER    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic [1:0] phase,
  output logic [3:0] dwell,
  output logic       sync_n,
  output logic       error,
  output logic [2:0] err_code,
  output logic [7:0] err_count,
  output logic       cycle_done,
  output logic [7:0] cycle_count
);

  localparam logic [3:0] C_RED_LIMIT    = 4'(REDTIMER);
  localparam logic [3:0] C_YELLOW_LIMIT = 4'(YELLOWTIMER);
  localparam logic [3:0] C_GREEN_LIMIT  = 4'(GREENTIMER);

  lamp_t     lamps;
  state_e    state_q;
  state_e    state_d;
  state_e    legal_state;
  logic      partial_q;
  logic      tracking;
  logic      same_lamp;
  logic      legal_move;
  logic [3:0] limit;
  logic      at_limit;
  logic      below_limit;
  err_code_t fault_code;
  logic      fault;
  logic      cnt_clr;
  logic      cnt_load;
  logic      cnt_inc;

  always_comb begin
    lamps                  = LAMP_NONE;
    lamps[LAMP_RED_BIT]    = red;
    lamps[LAMP_YELLOW_BIT] = yellow;
    lamps[LAMP_GREEN_BIT]  = green;
  end

  assign tracking  = (state_q != ST_SYNC);
  assign same_lamp = (lamps == state_lamp(state_q));

  always_comb begin
    limit = 4'd0;
    case (state_q)
      ST_RED:          limit = C_RED_LIMIT;
      ST_Y2G, ST_Y2R:  limit = C_YELLOW_LIMIT;
      ST_GREEN:        limit = C_GREEN_LIMIT;
      default:         limit = 4'd0;
    endcase
  end

  // The one lamp change allowed out of each tracking state
  always_comb begin
    legal_state = ST_SYNC;
    legal_move  = 1'b0;
    case (state_q)
      ST_RED:   if (lamps == LAMP_YELLOW) begin legal_state = ST_Y2G;   legal_move = 1'b1; end
      ST_Y2G:   if (lamps == LAMP_GREEN)  begin legal_state = ST_GREEN; legal_move = 1'b1; end
      ST_GREEN: if (lamps == LAMP_YELLOW) begin legal_state = ST_Y2R;   legal_move = 1'b1; end
      ST_Y2R:   if (lamps == LAMP_RED)    begin legal_state = ST_RED;   legal_move = 1'b1; end
      default:  ;
    endcase
  end

  // Priority chain keeps only the lowest code when several checks fire.
  // The first red phase after SYNC is entered part-way, so its short-dwell
  // check is suppressed by partial_q.
  always_comb begin
    fault_code = ERR_NONE;
    if (tracking) begin
      if (!is_onehot(lamps)) begin
        fault_code = ERR_NOT_ONEHOT;
      end else if (!same_lamp && !legal_move) begin
        fault_code = ERR_ILLEGAL;
      end else if (legal_move && !partial_q && below_limit) begin
        fault_code = ERR_SHORT;
      end else if (same_lamp && at_limit) begin
        fault_code = ERR_LONG;
      end
    end
  end

  assign fault = (fault_code != ERR_NONE);

  always_comb begin
    if (fault) begin
      state_d = ST_SYNC;
    end else if (!tracking) begin
      state_d = (lamps == LAMP_RED) ? ST_RED : ST_SYNC;
    end else if (legal_move) begin
      state_d = legal_state;
    end else begin
      state_d = state_q;
    end
  end

  assign cnt_clr  = fault || (!tracking && (lamps != LAMP_RED));
  assign cnt_load = !fault && ((!tracking && (lamps == LAMP_RED)) || legal_move);
  assign cnt_inc  = !fault && tracking && same_lamp;

  tl_dwell_counter #(
    .WIDTH (4)
  ) u_dwell (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (cnt_clr),
    .load_i        (cnt_load),
    .inc_i         (cnt_inc),
    .limit_i       (limit),
    .count_o       (dwell),
    .at_limit_o    (at_limit),
    .below_limit_o (below_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      partial_q   <= 1'b1;
      phase       <= PH_SYNC;
      sync_n      <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      err_count   <= 8'd0;
      cycle_done  <= 1'b0;
      cycle_count <= 8'd0;
    end else begin
      state_q    <= state_d;
      phase      <= state_phase(state_d);
      sync_n     <= (state_d != ST_SYNC);
      cycle_done <= 1'b0;
      if (fault) begin
        partial_q <= 1'b1;
        error     <= 1'b1;
        if (!error) begin
          err_code <= fault_code;
        end
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end else if (tracking && legal_move) begin
        if (state_q == ST_RED) begin
          partial_q <= 1'b0;
        end
        if (state_q == ST_Y2R) begin
          cycle_done  <= 1'b1;
          cycle_count <= cycle_count + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_monitor
// Purpose  : Self-checking bench for traffic_light_monitor. A cycle-position
//            reference model (index into the R,Y,G,Y sequence plus a hold
//            count) predicts every registered output after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

  localparam int RT = 8;
  localparam int YT = 2;
  localparam int GT = 6;

  localparam logic [2:0] L_R = 3'b001;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] lamps = 3'b000;
  logic [1:0] phase;
  logic [3:0] dwell;
  logic       sync_n;
  logic       error;
  logic [2:0] err_code;
  logic [7:0] err_count;
  logic       cycle_done;
  logic [7:0] cycle_count;

  int passed = 0;
  int total  = 0;
  int stepno = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .GREENTIMER  (GT),
    .YELLOWTIMER (YT),
    .REDTIMER    (RT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .red         (lamps[0]),
    .yellow      (lamps[1]),
    .green       (lamps[2]),
    .phase       (phase),
    .dwell       (dwell),
    .sync_n      (sync_n),
    .error       (error),
    .err_code    (err_code),
    .err_count   (err_count),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count)
  );

  // ---------------- reference model ----------------
  logic [2:0] seq [4] = '{L_R, L_Y, L_G, L_Y};
  int         tmr [4] = '{RT, YT, GT, YT};

  int m_pos = -1;   // position in the lamp sequence, -1 when not tracking
  int m_hold = 0;
  bit m_partial = 1'b1;
  bit m_err = 1'b0;
  int m_code = 0;
  int m_cnt = 0;
  bit m_done = 1'b0;
  int m_cc = 0;

  task automatic model_step(input logic [2:0] l, input logic r);
    int code;
    int nxt;
    m_done = 1'b0;
    if (r) begin
      m_pos = -1; m_hold = 0; m_partial = 1'b1; m_err = 1'b0;
      m_code = 0; m_cnt = 0; m_cc = 0;
      return;
    end
    if (m_pos < 0) begin
      if (l == L_R) begin m_pos = 0; m_hold = 1; m_partial = 1'b1; end
      else m_hold = 0;
      return;
    end
    code = 0;
    nxt  = (m_pos + 1) % 4;
    if ($countones(l) != 1) begin
      code = 1;
    end else if (l == seq[m_pos]) begin
      if (m_hold == tmr[m_pos]) code = 4;
      else m_hold = (m_hold < 15) ? m_hold + 1 : 15;
    end else if (l == seq[nxt]) begin
      if (!m_partial && (m_hold < tmr[m_pos])) begin
        code = 3;
      end else begin
        if (m_pos == 0) m_partial = 1'b0;
        if (m_pos == 3) begin m_done = 1'b1; m_cc = (m_cc + 1) % 256; end
        m_pos  = nxt;
        m_hold = 1;
      end
    end else begin
      code = 2;
    end
    if (code != 0) begin
      if (!m_err) begin m_err = 1'b1; m_code = code; end
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      m_pos = -1; m_hold = 0; m_partial = 1'b1;
    end
  endtask

  function automatic logic [27:0] exp_vec();
    logic [1:0] ph;
    logic       sn;
    ph = (m_pos < 0 || m_pos == 3) ? 2'd0 : 2'(m_pos + 1);
    sn = (m_pos >= 0);
    return {ph, 4'(m_hold), sn, m_err, 3'(m_code), 8'(m_cnt), m_done, 8'(m_cc)};
  endfunction

  function automatic logic [27:0] obs_vec();
    return {phase, dwell, sync_n, error, err_code, err_count, cycle_done, cycle_count};
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [2:0] stim [$];

  task automatic add(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) stim.push_back(l);
  endtask

  task automatic add_cycle();
    add(L_R, RT); add(L_Y, YT); add(L_G, GT); add(L_Y, YT);
  endtask

  // Inputs change 1 time unit after an edge; outputs are read 1 unit after the next edge
  task automatic step(input logic [2:0] l, input logic r);
    lamps = l;
    rst   = r;
    @(posedge clk);
    model_step(l, r);
    #1;
    stepno++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(3'($urandom_range(0, 7)), 1'b1);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_model step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
      total++;
      if (obs_vec() !== 28'd0) $display("FAIL reset_zero step %0d actual %h required 0", stepno, obs_vec());
      else passed++;
    end
  endtask

  task automatic test_nominal();
    int pulses [$];
    step(3'b000, 1'b1);
    add_cycle(); add_cycle(); add_cycle(); add(L_R, 1);
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL nominal step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
      if (cycle_done === 1'b1) pulses.push_back(i);
    end
    stim.delete();
    total++;
    if (cycle_count !== 8'd3) $display("FAIL nominal_count actual %0d required 3", cycle_count);
    else passed++;
    total++;
    if (error !== 1'b0) $display("FAIL nominal_error actual %b required 0", error);
    else passed++;
    total++;
    if (pulses.size() != 3) $display("FAIL nominal_pulses actual %0d required 3", pulses.size());
    else passed++;
    for (int i = 1; i < pulses.size(); i++) begin
      total++;
      if (pulses[i] - pulses[i-1] != 18) $display("FAIL nominal_period actual %0d required 18", pulses[i] - pulses[i-1]);
      else passed++;
    end
  endtask

  task automatic test_short_green();
    step(3'b000, 1'b1);
    add(L_R, RT); add(L_Y, YT); add(L_G, GT - 1); add(L_Y, 1);
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL short step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
    end
    stim.delete();
    total++;
    if ({err_code, err_count, sync_n, error} !== {3'd3, 8'd1, 1'b0, 1'b1})
      $display("FAIL short_fault actual code %0d cnt %0d sync_n %b required code 3 cnt 1 sync_n 0", err_code, err_count, sync_n);
    else passed++;
  endtask

  task automatic test_illegal();
    step(3'b000, 1'b1);
    add(L_R, RT); add(L_G, 1);
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL illegal step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
    end
    stim.delete();
    total++;
    if (err_code !== 3'd2) $display("FAIL illegal_code actual %0d required 2", err_code);
    else passed++;
  endtask

  task automatic test_not_onehot();
    step(3'b000, 1'b1);
    add(L_R, 3); add(3'b011, 1);
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL onehot step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
    end
    stim.delete();
    total++;
    if ({err_code, phase, sync_n} !== {3'd1, 2'd0, 1'b0})
      $display("FAIL onehot_code actual code %0d phase %0d required code 1 phase 0", err_code, phase);
    else passed++;
  endtask

  task automatic test_long_green();
    step(3'b000, 1'b1);
    add(L_R, RT); add(L_Y, YT); add(L_G, GT);
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL long step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
    end
    stim.delete();
    total++;
    if ({error, dwell} !== {1'b0, 4'd6}) $display("FAIL long_pre actual error %b dwell %0d required 0 6", error, dwell);
    else passed++;
    step(L_G, 1'b0);
    total++;
    if ({err_code, err_count} !== {3'd4, 8'd1}) $display("FAIL long_code actual %0d cnt %0d required 4 1", err_code, err_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    step(3'b000, 1'b1);
    add(L_R, RT); add(L_G, 1); add(L_R, RT); add(L_Y, YT); add(L_G, 3);
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL midrst_pre step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
    end
    stim.delete();
    total++;
    if ({error, phase} !== {1'b1, 2'd3}) $display("FAIL midrst_green actual error %b phase %0d required 1 3", error, phase);
    else passed++;
    step(L_G, 1'b1);
    total++;
    if (obs_vec() !== 28'd0) $display("FAIL midrst_zero actual %h required 0", obs_vec());
    else passed++;
    add_cycle(); add(L_R, 1);
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL midrst_post step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
    end
    stim.delete();
    total++;
    if ({cycle_count, error} !== {8'd1, 1'b0}) $display("FAIL midrst_count actual %0d error %b required 1 0", cycle_count, error);
    else passed++;
  endtask

  task automatic test_saturate();
    step(3'b000, 1'b1);
    for (int i = 0; i < 300; i++) begin add(L_R, 1); add(3'b000, 1); end
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL saturate step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
    end
    stim.delete();
    total++;
    if ({err_count, err_code} !== {8'd255, 3'd1}) $display("FAIL saturate_count actual %0d code %0d required 255 1", err_count, err_code);
    else passed++;
  endtask

  task automatic test_wrap();
    step(3'b000, 1'b1);
    for (int c = 0; c < 257; c++) add_cycle();
    add(L_R, 1);
    foreach (stim[i]) begin
      step(stim[i], 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL wrap step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
      else passed++;
    end
    stim.delete();
    total++;
    if (cycle_count !== 8'd1) $display("FAIL wrap_count actual %0d required 1", cycle_count);
    else passed++;
  endtask

  task automatic test_random();
    int g;
    int n;
    int t;
    int lo;
    int act;
    g = 0;
    step(3'b000, 1'b1);
    for (int k = 0; k < 120; k++) begin
      act = $urandom_range(0, 19);
      if (act == 0) begin
        stim.push_back(3'b111);  // marker consumed below as a reset cycle
      end else if (act == 1) begin
        add(3'($urandom_range(0, 7)), 1);
      end else begin
        t  = tmr[g];
        lo = (t > 1) ? t - 1 : 1;
        n  = $urandom_range(t + 1, lo);
        add(seq[g], n);
        g = (g + 1) % 4;
      end
      foreach (stim[i]) begin
        if (act == 0) step(3'($urandom_range(0, 7)), 1'b1);
        else step(stim[i], 1'b0);
        total++;
        if (obs_vec() !== exp_vec()) $display("FAIL random step %0d actual %h required %h", stepno, obs_vec(), exp_vec());
        else passed++;
      end
      stim.delete();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_green();
    test_illegal();
    test_not_onehot();
    test_long_green();
    test_reset_mid();
    test_saturate();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
